axi4lite_slave_regs: RTL and testbench

AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

---
 rtl/axi4lite_slave_regs.sv | 170 +++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regs.sv
// rtl/axi4lite_slave_regs.sv - AXI4-Lite register file slave; optional AXI4LITE_SLV_ERR_RESP_EN macro selects SLVERR for out-of-range accesses
module axi4lite_slave_regs #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 8
) (
    input  logic                               A_CLK,
    input  logic                               A_RST,
    input  logic                               AW_VALID,
    output logic                               AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]          AW_ADDR,
    input  logic                               W_VALID,
    output logic                               W_READY,
    input  logic [AXI_DATA_WIDTH-1:0]          W_DATA,
    output logic                               B_VALID,
    input  logic                               B_READY,
    output logic [1:0]                         B_RESP,
    input  logic                               AR_VALID,
    output logic                               AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]          AR_ADDR,
    output logic                               R_VALID,
    input  logic                               R_READY,
    output logic [AXI_DATA_WIDTH-1:0]          R_DATA,
    output logic [1:0]                         R_RESP,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REGS_OUT
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4LITE_SLV_ERR_RESP_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                      aw_captured, w_captured;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic                      aw_hs, w_hs, ar_hs, wr_commit;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic                      wr_in_range, rd_in_range;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic [1:0]                b_resp_q, r_resp_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    assign aw_hs = AW_VALID && AW_READY;
    assign w_hs  = W_VALID && W_READY;
    assign ar_hs = AR_VALID && AR_READY;

    // A piece arriving in the commit cycle is used directly, otherwise the captured copy
    assign wr_addr     = aw_captured ? aw_addr_q : AW_ADDR;
    assign wr_data     = w_captured  ? w_data_q  : W_DATA;
    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign rd_idx      = AR_ADDR[IDX_W+1:2];
    assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;
    assign rd_in_range = (AR_ADDR >> (IDX_W + 2)) == '0;

    assign B_RESP = b_resp_q;
    assign R_RESP = r_resp_q;
    assign R_DATA = r_data_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign REGS_OUT[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
    end

    // Write FSM state register
    always_ff @(posedge A_CLK) begin
        if (A_RST) wr_state <= WR_IDLE;
        else       wr_state <= wr_state_next;
    end

    // Write FSM: ready per channel until captured, commit once both address and data are held
    always_comb begin
        wr_state_next = wr_state;
        AW_READY      = 1'b0;
        W_READY       = 1'b0;
        B_VALID       = 1'b0;
        wr_commit     = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                AW_READY = !aw_captured;
                W_READY  = !w_captured;
                if ((aw_captured || AW_VALID) && (w_captured || W_VALID)) begin
                    wr_commit     = 1'b1;
                    wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                B_VALID = 1'b1;
                if (B_READY) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    // Capture address and data independently; flags clear when the write commits
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            b_resp_q    <= RESP_OKAY;
        end else if (wr_commit) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            b_resp_q    <= wr_in_range ? RESP_OKAY : RESP_OOR;
        end else begin
            if (aw_hs) begin
                aw_captured <= 1'b1;
                aw_addr_q   <= AW_ADDR;
            end
            if (w_hs) begin
                w_captured <= 1'b1;
                w_data_q   <= W_DATA;
            end
        end
    end

    // Register file; out-of-range writes are dropped
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_commit && wr_in_range) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Read FSM state register
    always_ff @(posedge A_CLK) begin
        if (A_RST) rd_state <= RD_IDLE;
        else       rd_state <= rd_state_next;
    end

    // Read FSM: accept one address, then hold the data beat until taken
    always_comb begin
        rd_state_next = rd_state;
        AR_READY      = 1'b0;
        R_VALID       = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                AR_READY = 1'b1;
                if (AR_VALID) rd_state_next = RD_DATA;
            end
            RD_DATA: begin
                R_VALID = 1'b1;
                if (R_READY) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // Read data sampled at the address handshake, so a same-edge write is not visible
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_data_q <= rd_in_range ? regs[rd_idx] : '0;
            r_resp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
        end
    end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb/tb_axi4lite_slave_regs.sv - scoreboard bench for axi4lite_slave_regs
module tb_axi4lite_slave_regs;
    localparam int NUM_REGS = 8;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI4LITE_SLV_ERR_RESP_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic                  A_CLK = 1'b0;
    logic                  A_RST;
    logic                  AW_VALID, AW_READY, W_VALID, W_READY;
    logic [31:0]           AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic                  B_VALID, B_READY, AR_VALID, AR_READY, R_VALID, R_READY;
    logic [1:0]            B_RESP, R_RESP;
    logic [NUM_REGS*32-1:0] REGS_OUT;

    int          n_checks = 0;
    int          n_errors = 0;
    int          b_count  = 0;
    logic [1:0]  exp_b [$];
    rexp_t       exp_r [$];
    logic [31:0] model [NUM_REGS];

    axi4lite_slave_regs #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .A_CLK(A_CLK), .A_RST(A_RST),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .REGS_OUT(REGS_OUT)
    );

    always #5 A_CLK = ~A_CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return a < NUM_REGS * 4;
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("reg%0d", i), REGS_OUT[i*32 +: 32], model[i]);
    endtask

    task automatic monitor();
        logic [1:0] eb;
        rexp_t      er;
        forever begin
            @(negedge A_CLK);
            if (!A_RST) begin
                if (B_VALID && B_READY) begin
                    b_count++;
                    if (exp_b.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL b_unexpected: got resp 0x%0h expected no response", B_RESP);
                    end else begin
                        eb = exp_b.pop_front();
                        check("b_resp", B_RESP, eb);
                    end
                end
                if (R_VALID && R_READY) begin
                    if (exp_r.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL r_unexpected: got data 0x%0h expected no response", R_DATA);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_data", R_DATA, er.data);
                        check("r_resp", R_RESP, er.resp);
                    end
                end
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input bit expect_b);
        bit aw_done, w_done, aw_now, w_now;
        aw_done = 0; w_done = 0;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c == aw_dly) begin AW_VALID = 1; AW_ADDR = addr; end
            if (c == w_dly)  begin W_VALID = 1;  W_DATA = data;  end
            @(negedge A_CLK);
            aw_now = AW_VALID && AW_READY;
            w_now  = W_VALID && W_READY;
            if (w_done && !aw_done) check("w_ready_drop", W_READY, 0);
            if (aw_done && !w_done) check("aw_ready_drop", AW_READY, 0);
            @(posedge A_CLK); #1;
            if (aw_now) begin AW_VALID = 0; aw_done = 1; end
            if (w_now)  begin W_VALID = 0;  w_done = 1;  end
        end
        check("write_handshake", {aw_done, w_done}, 2'b11);
        if (expect_b) begin
            exp_b.push_back(m_in_range(addr) ? OKAY : OOR);
            if (m_in_range(addr)) model[addr / 4] = data;
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit done, now;
        rexp_t er;
        done = 0;
        AR_VALID = 1; AR_ADDR = addr;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge A_CLK);
            now = AR_VALID && AR_READY;
            @(posedge A_CLK); #1;
            if (now) begin AR_VALID = 0; done = 1; end
        end
        check("read_handshake", done, 1);
        er.data = m_in_range(addr) ? model[addr / 4] : 32'h0;
        er.resp = m_in_range(addr) ? OKAY : OOR;
        exp_r.push_back(er);
    endtask

    task automatic wait_idle(input bit rnd);
        int c;
        for (c = 0; c < 60; c++) begin
            if (exp_b.size() == 0 && exp_r.size() == 0) break;
            @(posedge A_CLK); #1;
            if (rnd) begin
                B_READY = 1'($urandom_range(0, 1));
                R_READY = 1'($urandom_range(0, 1));
            end
        end
        if (c == 60) begin
            n_checks++; n_errors++;
            $display("FAIL response_timeout: got %0d b and %0d r pending expected 0", exp_b.size(), exp_r.size());
            exp_b.delete(); exp_r.delete();
        end
    endtask

    task automatic apply_reset();
        A_RST = 1; AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
        @(posedge A_CLK); #1;
        @(negedge A_CLK);
        check("rst_b_valid", B_VALID, 0);
        check("rst_r_valid", R_VALID, 0);
        check("rst_b_resp", B_RESP, 0);
        check("rst_r_resp", R_RESP, 0);
        check("rst_r_data", R_DATA, 0);
        check("rst_regs_zero", REGS_OUT == '0, 1);
        @(posedge A_CLK); #1;
        A_RST = 0;
        @(posedge A_CLK); #1;
        @(negedge A_CLK);
        check("post_rst_readys", {AW_READY, W_READY, AR_READY}, 3'b111);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        exp_b.delete(); exp_r.delete();
        @(posedge A_CLK); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          b_before;
        logic [31:0] a;
        rexp_t       er;
        A_RST = 1; AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
        AW_ADDR = 0; W_DATA = 0; AR_ADDR = 0; B_READY = 1; R_READY = 1;
        fork monitor(); join_none
        apply_reset();

        // same-cycle AW+W
        do_write(32'h04, 32'hDEADBEEF, 0, 0, 1);
        @(negedge A_CLK);
        check("b_valid_one_cycle", B_VALID, 1);
        wait_idle(0);
        check_regs();

        // W three cycles ahead of AW
        b_before = b_count;
        do_write(32'h08, 32'h12345678, 3, 0, 1);
        wait_idle(0);
        check("b_single_pulse", b_count - b_before, 1);
        check_regs();

        // read held off by R_READY=0
        R_READY = 0;
        do_read(32'h04);
        for (int i = 0; i < 4; i++) begin
            @(negedge A_CLK);
            check("hold_r_valid", R_VALID, 1);
            check("hold_r_data", R_DATA, 32'hDEADBEEF);
            check("hold_ar_ready", AR_READY, 0);
        end
        @(posedge A_CLK); #1;
        R_READY = 1;
        wait_idle(0);

        // read captured on the edge a write to the same register commits
        AW_VALID = 1; AW_ADDR = 32'h0C; W_VALID = 1; W_DATA = 32'hA5;
        AR_VALID = 1; AR_ADDR = 32'h0C;
        @(negedge A_CLK);
        check("concurrent_readys", {AW_READY, W_READY, AR_READY}, 3'b111);
        exp_b.push_back(OKAY);
        er.data = model[3]; er.resp = OKAY;
        exp_r.push_back(er);
        model[3] = 32'hA5;
        @(posedge A_CLK); #1;
        AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
        wait_idle(0);
        do_read(32'h0C);
        wait_idle(0);

        // out-of-range write then read
        do_write(32'h40, 32'hCAFEF00D, 0, 1, 1);
        wait_idle(0);
        check_regs();
        do_read(32'h40);
        wait_idle(0);

        // reset while the write response is pending
        B_READY = 0;
        do_write(32'h10, 32'h5A5A5A5A, 0, 0, 0);
        @(negedge A_CLK);
        check("in_wr_resp", B_VALID, 1);
        apply_reset();
        B_READY = 1;

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 32'h4F));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1);
            else
                do_read(a);
            wait_idle(1);
        end
        B_READY = 1; R_READY = 1;
        check_regs();
        for (int i = 0; i < NUM_REGS; i++) begin
            do_read(32'(i * 4));
            wait_idle(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
